// File: rtl/fpaddsub_pkg.sv
// Shared widths, constants and stage payloads for the FP add/sub rounding pipeline.
package fpaddsub_pkg;

    localparam int unsigned EXP_W = 3;
    localparam int unsigned FRAC_W = 3;
    localparam int unsigned RES_W = 1 + EXP_W + FRAC_W;
    localparam logic [EXP_W-1:0] EXP_INF = 3'b111;

    // S1: rounding already applied; hidden bit dropped since only the fraction is packed.
    typedef struct packed {
        logic              sign;
        logic              zero;
        logic              neg_e;
        logic              nx;
        logic [EXP_W:0]    expn;
        logic [FRAC_W-1:0] frac;
    } s1_payload_t;

    typedef struct packed {
        logic [RES_W-1:0] result;
        logic             of;
        logic             uf;
        logic             nx;
    } s2_payload_t;

endpackage

// File: rtl/fpaddsub_round_core.sv
// Combinational round-to-nearest-even and result classification/packing.
module fpaddsub_round_core
    import fpaddsub_pkg::*;
(
    input  logic [FRAC_W:0]  i_norm_m,
    input  logic [EXP_W:0]   i_norm_e,
    input  logic             i_zero_sum,
    input  logic             i_neg_e,
    input  logic             i_fg,
    input  logic             i_r,
    input  logic             i_s,
    input  logic             i_sign,
    output s1_payload_t      o_s1,
    input  s1_payload_t      i_s1,
    output s2_payload_t      o_s2
);

    logic              w_round_up;
    logic              w_carry;
    logic [FRAC_W-1:0] w_frac;

    always_comb begin
        w_round_up = i_fg & (i_r | i_s | i_norm_m[0]);
        // Mantissa carry-out only when all four bits are set; fraction wraps to 000 then.
        w_carry    = w_round_up & (&i_norm_m);
        w_frac     = i_norm_m[FRAC_W-1:0] + FRAC_W'(w_round_up);

        o_s1       = '0;
        o_s1.sign  = i_sign;
        o_s1.zero  = i_zero_sum;
        o_s1.neg_e = i_neg_e;
        o_s1.nx    = i_fg | i_r | i_s;
        o_s1.expn  = i_norm_e + (EXP_W + 1)'(w_carry);
        o_s1.frac  = w_frac;
    end

    always_comb begin
        o_s2 = '0;
        if (!i_s1.zero) begin
            if (i_s1.neg_e || (i_s1.expn == '0)) begin
                o_s2.result = {i_s1.sign, {(RES_W - 1){1'b0}}};
                o_s2.uf     = 1'b1;
                o_s2.nx     = 1'b1;
            end else if (i_s1.expn >= {1'b0, EXP_INF}) begin
                o_s2.result = {i_s1.sign, EXP_INF, {FRAC_W{1'b0}}};
                o_s2.of     = 1'b1;
                o_s2.nx     = 1'b1;
            end else begin
                o_s2.result = {i_s1.sign, i_s1.expn[EXP_W-1:0], i_s1.frac};
                o_s2.nx     = i_s1.nx;
            end
        end
    end

endmodule

// File: rtl/fpaddsub_round_pipe.sv
// Two-stage valid/ready rounding pipeline with sticky exception flags.
module fpaddsub_round_pipe
    import fpaddsub_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FRAC_W:0]  norm_m,
    input  logic [EXP_W:0]   norm_e,
    input  logic             zero_sum,
    input  logic             neg_e,
    input  logic             fg,
    input  logic             r,
    input  logic             s,
    input  logic             sign_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] result,
    output logic             of,
    output logic             uf,
    output logic             nx,
    input  logic             clr_flags,
    output logic [2:0]       flags_sticky
);

    s1_payload_t w_s1_d;
    s2_payload_t w_s2_d;
    s1_payload_t r_s1;
    s2_payload_t r_s2;
    logic        r_s1_valid;
    logic        r_s2_valid;
    logic [2:0]  r_flags_sticky;
    logic        w_s2_adv;
    logic        w_s1_adv;
    logic        w_out_xfer;
    logic [2:0]  w_out_flags;

    fpaddsub_round_core u_core (
        .i_norm_m   (norm_m),
        .i_norm_e   (norm_e),
        .i_zero_sum (zero_sum),
        .i_neg_e    (neg_e),
        .i_fg       (fg),
        .i_r        (r),
        .i_s        (s),
        .i_sign     (sign_in),
        .o_s1       (w_s1_d),
        .i_s1       (r_s1),
        .o_s2       (w_s2_d)
    );

    always_comb begin
        w_s2_adv    = ~r_s2_valid | out_ready;
        w_s1_adv    = ~r_s1_valid | w_s2_adv;
        w_out_xfer  = r_s2_valid & out_ready;
        w_out_flags = {r_s2.of, r_s2.uf, r_s2.nx};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
            r_s2_valid <= 1'b0;
            r_s2       <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1 <= w_s1_d;
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2 <= w_s2_d;
                end
            end
        end
    end

    // A clear coinciding with a transfer keeps that transfer's flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags_sticky <= '0;
        end else if (clr_flags) begin
            r_flags_sticky <= w_out_xfer ? w_out_flags : 3'b000;
        end else if (w_out_xfer) begin
            r_flags_sticky <= r_flags_sticky | w_out_flags;
        end
    end

    assign in_ready     = w_s1_adv;
    assign out_valid    = r_s2_valid;
    assign result       = r_s2.result;
    assign of           = r_s2.of;
    assign uf           = r_s2.uf;
    assign nx           = r_s2.nx;
    assign flags_sticky = r_flags_sticky;

endmodule

// File: tb/tb_fpaddsub_round_pipe.sv
// Self-checking bench: directed vectors, backpressure, reset and randomized traffic vs a model.
module tb_fpaddsub_round_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] norm_m = 4'h8;
    logic [3:0] norm_e = 4'h1;
    logic       zero_sum = 1'b0, neg_e = 1'b0, fg = 1'b0, r = 1'b0, s = 1'b0, sign_in = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [6:0] result;
    logic       of, uf, nx;
    logic       clr_flags = 1'b0;
    logic [2:0] flags_sticky;

    fpaddsub_round_pipe dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .norm_m       (norm_m),
        .norm_e       (norm_e),
        .zero_sum     (zero_sum),
        .neg_e        (neg_e),
        .fg           (fg),
        .r            (r),
        .s            (s),
        .sign_in      (sign_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .of           (of),
        .uf           (uf),
        .nx           (nx),
        .clr_flags    (clr_flags),
        .flags_sticky (flags_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] res;
        logic [2:0] flags;
    } exp_t;

    exp_t       q[$];
    int         errors = 0;
    int         checks = 0;
    logic [2:0] m_sticky = 3'b000;
    logic       hold_v = 1'b0;
    logic [9:0] hold_val;
    logic       last_acc = 1'b0;
    logic       obs_ov = 1'b0;
    logic [6:0] last_res = 7'h00;
    logic [2:0] last_flags = 3'b000;

    // Reference: plain integer arithmetic over the rounding/classification rules.
    function automatic exp_t model(input logic [3:0] m, input logic [3:0] e, input logic z,
                                   input logic ng, input logic g, input logic rr,
                                   input logic ss, input logic sg);
        exp_t t;
        int   rup, mant, ex;
        rup  = (g && (rr || ss || m[0])) ? 1 : 0;
        mant = int'(m) + rup;
        ex   = int'(e);
        if (mant >= 16) begin
            mant = 8;
            ex   = (ex + 1) % 16;
        end
        if (z) begin
            t.res = 7'd0; t.flags = 3'b000;
        end else if (ng || ex == 0) begin
            t.res = {sg, 6'd0}; t.flags = 3'b011;
        end else if (ex >= 7) begin
            t.res = {sg, 6'b111000}; t.flags = 3'b101;
        end else begin
            t.res = {sg, 3'(ex), 3'(mant)}; t.flags = {2'b00, g | rr | ss};
        end
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // One clock: sample at negedge, score transfers, update models, return at posedge+1.
    task automatic cycle();
        exp_t       e;
        logic [2:0] f;
        logic       iacc, oacc;
        @(negedge clk);
        chk("sticky", {29'd0, flags_sticky}, {29'd0, m_sticky});
        if (hold_v) chk("hold", {21'd0, out_valid, result, of, uf, nx}, {21'd0, 1'b1, hold_val});
        iacc   = in_valid & in_ready;
        oacc   = out_valid & out_ready;
        obs_ov = out_valid;
        f      = 3'b000;
        if (oacc) begin
            if (q.size() == 0) begin
                chk("spurious_out", {31'd0, out_valid}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("result", {25'd0, result}, {25'd0, e.res});
                chk("flags", {29'd0, of, uf, nx}, {29'd0, e.flags});
                f = e.flags;
            end
            last_res   = result;
            last_flags = {of, uf, nx};
        end
        m_sticky = clr_flags ? f : (m_sticky | f);
        hold_v   = out_valid & ~out_ready;
        hold_val = {result, of, uf, nx};
        if (iacc) q.push_back(model(norm_m, norm_e, zero_sum, neg_e, fg, r, s, sign_in));
        last_acc = iacc;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] m, input logic [3:0] e, input logic z,
                          input logic ng, input logic g, input logic rr, input logic ss,
                          input logic sg);
        norm_m = m; norm_e = e; zero_sum = z; neg_e = ng; fg = g; r = rr; s = ss; sign_in = sg;
    endtask

    task automatic send(input logic [3:0] m, input logic [3:0] e, input logic z,
                        input logic ng, input logic g, input logic rr, input logic ss,
                        input logic sg);
        set_in(m, e, z, ng, g, rr, ss, sg);
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (last_acc) break;
        end
        if (!last_acc) chk("accept_timeout", {31'd0, last_acc}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic rand_in();
        logic ng;
        ng = ($urandom_range(7) == 0);
        set_in(4'(8 + $urandom_range(7)), {ng, 3'($urandom_range(7))},
               ($urandom_range(7) == 0), ng, 1'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom));
    endtask

    initial begin
        int n;
        // Reset state
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", {25'd0, result, of, uf, nx} >> 3, 32'd0);
        chk("rst_flagbits", {29'd0, of, uf, nx}, 32'd0);
        chk("rst_sticky", {29'd0, flags_sticky}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Basic round-up with latency probe
        out_ready = 1'b1;
        send(4'b1011, 4'b0011, 0, 0, 1, 0, 0, 0);
        cycle();
        chk("lat_stage1", {31'd0, obs_ov}, 32'd0);
        cycle();
        chk("lat_stage2", {31'd0, obs_ov}, 32'd1);
        chk("vec029_res", {25'd0, last_res}, 32'h1C);
        chk("vec029_flags", {29'd0, last_flags}, 32'b001);

        // Mantissa carry into exponent
        send(4'b1111, 4'b0010, 0, 0, 1, 1, 0, 0);
        cycle(); cycle();
        chk("vec030_res", {25'd0, last_res}, 32'h18);
        chk("vec030_flags", {29'd0, last_flags}, 32'b001);

        // Overflow after clearing the sticky flags
        clr_flags = 1'b1;
        cycle();
        clr_flags = 1'b0;
        send(4'b1111, 4'b0110, 0, 0, 1, 1, 0, 1);
        cycle(); cycle();
        chk("vec031_res", {25'd0, last_res}, 32'h78);
        chk("vec031_flags", {29'd0, last_flags}, 32'b101);
        chk("vec031_sticky", {29'd0, flags_sticky}, 32'b101);

        // Tie to even, negative exponent, zero sum
        send(4'b1010, 4'b0001, 0, 0, 1, 0, 0, 0);
        cycle(); cycle();
        chk("vec032_tie_res", {25'd0, last_res}, 32'h0A);
        chk("vec032_tie_flags", {29'd0, last_flags}, 32'b001);
        send(4'b1100, 4'b1110, 0, 1, 0, 0, 0, 1);
        cycle(); cycle();
        chk("vec032_uf_res", {25'd0, last_res}, 32'h40);
        chk("vec032_uf_flags", {29'd0, last_flags}, 32'b011);
        send(4'b1001, 4'b0100, 1, 0, 1, 1, 1, 1);
        cycle(); cycle();
        chk("zero_res", {25'd0, last_res}, 32'h00);
        chk("zero_flags", {29'd0, last_flags}, 32'b000);

        // Back-to-back inputs against a stalled output
        out_ready = 1'b0;
        n = 0;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_in(4'(9 + n), 4'(2 + n), 0, 0, 1'(n), 1'(n >> 1), 0, 1'(n));
            cycle();
            if (last_acc) n++;
        end
        chk("bp_accepts", n, 2);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 20 && n < 4; k++) begin
            set_in(4'(9 + n), 4'(2 + n), 0, 0, 1'(n), 1'(n >> 1), 0, 1'(n));
            cycle();
            if (last_acc) n++;
        end
        in_valid = 1'b0;
        chk("bp_all_accepted", n, 4);
        for (int k = 0; k < 6; k++) cycle();
        chk("bp_drained", q.size(), 0);

        // Randomized traffic with random backpressure and clears
        for (int k = 0; k < 400; k++) begin
            rand_in();
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(9) < 7);
            clr_flags = ($urandom_range(19) == 0);
            cycle();
        end
        in_valid  = 1'b0;
        clr_flags = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) cycle();
        chk("rand_drained", q.size(), 0);

        // Mid-flight reset discards two bundles
        send(4'b1111, 4'b0110, 0, 0, 1, 1, 0, 0);
        out_ready = 1'b0;
        send(4'b1011, 4'b0011, 0, 0, 1, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_sticky", {29'd0, flags_sticky}, 32'd0);
        q.delete();
        m_sticky = 3'b000;
        hold_v   = 1'b0;
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("no_stale_out", {31'd0, obs_ov}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
